// File: rtl/gpu_pkg.sv
// Shared GPU core types: pipeline state encoding and warp scheduler constants.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6
    } core_state_t;

    localparam int WARP_SCHED_CNT_W = 32;

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [WARP_SCHED_CNT_W-1:0] sat_inc(input logic [WARP_SCHED_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_next_warp.sv
// Round-robin picker: first unfinished warp after cur_warp, wrapping, with cur_warp itself considered last.
module rr_next_warp #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_W    = 2
) (
    input  logic [NUM_WARPS-1:0] warp_done,
    input  logic [WARP_W-1:0]    cur_warp,
    output logic [WARP_W-1:0]    next_warp,
    output logic                 any_left
);

    int idx;

    // Scanning from the farthest offset down lets the nearest candidate win.
    always_comb begin
        next_warp = cur_warp;
        any_left  = 1'b0;
        idx       = 0;
        for (int k = NUM_WARPS; k >= 1; k--) begin
            idx = (int'(cur_warp) + k) % NUM_WARPS;
            if (!warp_done[idx[WARP_W-1:0]]) begin
                next_warp = idx[WARP_W-1:0];
                any_left  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp core scheduler: per-warp PCs, round-robin switching after each instruction, divergence flag.
// Define WARP_SCHED_PERF_EN to build the saturating cycle/instruction counters; otherwise they read 0.
module warp_scheduler
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH       = 8,
    parameter int THREADS_PER_WARP = 4,
    parameter int NUM_WARPS        = 4,
    localparam int WARP_W          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WARP_W:0]             warp_count,
    input  logic [THREADS_PER_WARP-1:0] thread_mask,
    input  logic                        fetch_done,
    input  logic                        mem_read_en,
    input  logic                        mem_write_en,
    input  logic                        is_ret,
    input  logic [THREADS_PER_WARP-1:0] lsu_done,
    input  logic [ADDR_WIDTH-1:0]       next_pc [THREADS_PER_WARP],
    output core_state_t                 core_state,
    output logic [ADDR_WIDTH-1:0]       current_pc,
    output logic [WARP_W-1:0]           current_warp,
    output logic [NUM_WARPS-1:0]        warp_done,
    output logic                        diverged,
    output logic                        done,
    output logic [WARP_SCHED_CNT_W-1:0] cycle_count,
    output logic [WARP_SCHED_CNT_W-1:0] instr_count
);

    localparam int TIDX_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

    core_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q [NUM_WARPS];
    logic [ADDR_WIDTH-1:0] pc_d [NUM_WARPS];
    logic [WARP_W-1:0]     cur_q, cur_d;
    logic [NUM_WARPS-1:0]  warp_done_q, warp_done_d, done_after_upd;
    logic                  diverged_q, diverged_d;
    logic                  done_q, done_d;

    logic [TIDX_W-1:0]     lead;
    logic [ADDR_WIDTH-1:0] lead_pc;
    logic                  any_diff;
    logic                  lsu_ok;
    logic [WARP_W-1:0]     rr_next;
    logic                  rr_any;
    int                    eff_count;

    // Lowest active thread leads the warp; an empty mask falls back to thread 0.
    always_comb begin
        lead = '0;
        for (int i = THREADS_PER_WARP - 1; i >= 0; i--) begin
            if (thread_mask[i]) begin
                lead = TIDX_W'(i);
            end
        end
        lead_pc  = next_pc[lead];
        any_diff = 1'b0;
        for (int i = 0; i < THREADS_PER_WARP; i++) begin
            if (thread_mask[i] && (next_pc[i] != lead_pc)) begin
                any_diff = 1'b1;
            end
        end
        lsu_ok         = &(lsu_done | ~thread_mask);
        done_after_upd = warp_done_q;
        if (is_ret) begin
            done_after_upd[cur_q] = 1'b1;
        end
    end

    always_comb begin
        if (warp_count == '0) begin
            eff_count = 1;
        end else if (int'(warp_count) > NUM_WARPS) begin
            eff_count = NUM_WARPS;
        end else begin
            eff_count = int'(warp_count);
        end
    end

    rr_next_warp #(
        .NUM_WARPS (NUM_WARPS),
        .WARP_W    (WARP_W)
    ) u_rr (
        .warp_done (done_after_upd),
        .cur_warp  (cur_q),
        .next_warp (rr_next),
        .any_left  (rr_any)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cur_d       = cur_q;
        warp_done_d = warp_done_q;
        diverged_d  = diverged_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_WARPS; i++) begin
                        pc_d[i]        = '0;
                        warp_done_d[i] = (i >= eff_count);
                    end
                    cur_d      = '0;
                    done_d     = 1'b0;
                    diverged_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH:   if (fetch_done) state_d = DECODE;
            DECODE:  state_d = REQUEST;
            REQUEST: state_d = (mem_read_en || mem_write_en) ? WAIT : EXECUTE;
            WAIT:    if (lsu_ok) state_d = EXECUTE;
            EXECUTE: state_d = UPDATE;
            UPDATE: begin
                if (!is_ret) begin
                    pc_d[cur_q] = lead_pc;
                end
                warp_done_d = done_after_upd;
                if (any_diff) begin
                    diverged_d = 1'b1;
                end
                if (rr_any) begin
                    cur_d   = rr_next;
                    state_d = FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_WARPS; i++) begin
                pc_q[i] <= '0;
            end
            cur_q       <= '0;
            warp_done_q <= '0;
            diverged_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cur_q       <= cur_d;
            warp_done_q <= warp_done_d;
            diverged_q  <= diverged_d;
            done_q      <= done_d;
        end
    end

    assign core_state   = state_q;
    assign current_pc   = pc_q[cur_q];
    assign current_warp = cur_q;
    assign warp_done    = warp_done_q;
    assign diverged     = diverged_q;
    assign done         = done_q;

`ifdef WARP_SCHED_PERF_EN
    logic [WARP_SCHED_CNT_W-1:0] cycle_q, cycle_d;
    logic [WARP_SCHED_CNT_W-1:0] instr_q, instr_d;

    // Counters restart with each accepted kernel launch.
    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (state_q == IDLE && start) begin
            cycle_d = '0;
            instr_d = '0;
        end else begin
            if (state_q != IDLE) cycle_d = sat_inc(cycle_q);
            if (state_q == UPDATE) instr_d = sat_inc(instr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: directed vector table, hand sequences and randomized kernels vs a warp-level model.
module tb_warp_scheduler;
    import gpu_pkg::*;

    localparam int NW  = 4;
    localparam int TPW = 4;
`ifdef WARP_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, fetch_done, mem_read_en, mem_write_en, is_ret;
    logic [2:0]  warp_count;
    logic [3:0]  thread_mask, lsu_done;
    logic [7:0]  next_pc [TPW];
    core_state_t core_state;
    logic [7:0]  current_pc;
    logic [1:0]  current_warp;
    logic [3:0]  warp_done;
    logic        diverged, done;
    logic [31:0] cycle_count, instr_count;

    warp_scheduler #(.ADDR_WIDTH(8), .THREADS_PER_WARP(TPW), .NUM_WARPS(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .warp_count(warp_count),
        .thread_mask(thread_mask), .fetch_done(fetch_done),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .is_ret(is_ret),
        .lsu_done(lsu_done), .next_pc(next_pc), .core_state(core_state),
        .current_pc(current_pc), .current_warp(current_warp), .warp_done(warp_done),
        .diverged(diverged), .done(done), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      fetchDly;
        logic            mem;
        logic            rd;
        logic [3:0][2:0] lsuDly;
        logic            ret;
        logic [3:0][7:0] npc;
    } instr_t;

    typedef struct packed {
        instr_t     ins;
        logic [7:0] expPc;
        logic       expDiv;
        logic [3:0] expWait;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Warp-level reference model
    logic [7:0]    mPc [NW];
    logic [NW-1:0] mDone;
    int            mCur;
    logic          mDiv;
    logic          mRunning;
    int            mCycles, mInstrs;
    time           tStart;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic instr_t mkIns(input logic [3:0] mask, input logic mem, input logic [11:0] dly,
                                     input logic ret, input logic [31:0] npc, input logic [2:0] fdly);
        instr_t i;
        i          = '0;
        i.mask     = mask;
        i.mem      = mem;
        i.rd       = 1'b1;
        i.lsuDly   = dly;
        i.ret      = ret;
        i.npc      = npc;
        i.fetchDly = fdly;
        return i;
    endfunction

    function automatic instr_t randIns();
        instr_t i;
        logic [7:0] base;
        i          = '0;
        i.mask     = 4'($urandom);
        i.fetchDly = 3'($urandom_range(0, 3));
        i.mem      = ($urandom_range(0, 2) == 0);
        i.rd       = 1'($urandom);
        for (int t = 0; t < TPW; t++) i.lsuDly[t] = 3'($urandom_range(0, 4));
        i.ret      = ($urandom_range(0, 3) == 0);
        base       = 8'($urandom);
        for (int t = 0; t < TPW; t++) i.npc[t] = base;
        if ($urandom_range(0, 3) == 0) i.npc[$urandom_range(0, 3)] = 8'($urandom);
        return i;
    endfunction

    task automatic startKernel(input int wc);
        int n;
        checkOutput("idle_before_start", core_state, IDLE);
        start      = 1'b1;
        warp_count = 3'(wc);
        n = (wc == 0) ? 1 : ((wc > NW) ? NW : wc);
        for (int i = 0; i < NW; i++) begin
            mPc[i]   = 8'd0;
            mDone[i] = (i >= n);
        end
        mCur = 0; mDiv = 1'b0; mRunning = 1'b1; mCycles = 0; mInstrs = 0;
        @(negedge clk);
        start  = 1'b0;
        tStart = $time;
        checkOutput("start_state", core_state, FETCH);
        checkOutput("start_warp_done", warp_done, mDone);
        checkOutput("start_diverged", diverged, mDiv);
        checkOutput("start_done", done, 0);
        checkOutput("start_cycle_count", cycle_count, 0);
        checkOutput("start_instr_count", instr_count, 0);
    endtask

    // Drives one instruction through the pipeline from FETCH entry to the cycle after UPDATE.
    task automatic applyStimulus(input instr_t ins, output int measW);
        int w, expW, l, nxt;
        bit found;
        checkOutput("fetch_state", core_state, FETCH);
        checkOutput("current_warp", current_warp, mCur);
        checkOutput("current_pc", current_pc, mPc[mCur]);
        thread_mask = ins.mask;
        for (int k = 0; k <= int'(ins.fetchDly); k++) begin
            fetch_done = (k == int'(ins.fetchDly));
            if (k > 0) checkOutput("fetch_hold", core_state, FETCH);
            @(negedge clk);
        end
        fetch_done = 1'b0;
        checkOutput("decode_state", core_state, DECODE);
        mem_read_en  = ins.mem & ins.rd;
        mem_write_en = ins.mem & ~ins.rd;
        start        = 1'($urandom);
        warp_count   = 3'd1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("request_state", core_state, REQUEST);
        @(negedge clk);
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        w = 0;
        while (core_state == WAIT && w < 64) begin
            for (int t = 0; t < TPW; t++) lsu_done[t] = (w >= int'(ins.lsuDly[t]));
            w++;
            @(negedge clk);
        end
        lsu_done = 4'b0;
        expW = 0;
        if (ins.mem) begin
            expW = 1;
            for (int t = 0; t < TPW; t++)
                if (ins.mask[t] && int'(ins.lsuDly[t]) + 1 > expW) expW = int'(ins.lsuDly[t]) + 1;
        end
        measW = w;
        checkOutput("wait_length", w, expW);
        checkOutput("execute_state", core_state, EXECUTE);
        is_ret = ins.ret;
        for (int t = 0; t < TPW; t++) next_pc[t] = ins.npc[t];
        @(negedge clk);
        checkOutput("update_state", core_state, UPDATE);
        @(negedge clk);
        is_ret = 1'b0;

        l = 0;
        for (int t = TPW - 1; t >= 0; t--) if (ins.mask[t]) l = t;
        for (int t = 0; t < TPW; t++) if (ins.mask[t] && ins.npc[t] != ins.npc[l]) mDiv = 1'b1;
        if (ins.ret) mDone[mCur] = 1'b1;
        else         mPc[mCur] = ins.npc[l];
        mInstrs++;
        mCycles += int'(ins.fetchDly) + 1 + 2 + expW + 2;
        found = 1'b0; nxt = 0;
        for (int k = 1; k <= NW; k++) begin
            if (!found && !mDone[(mCur + k) % NW]) begin
                found = 1'b1;
                nxt   = (mCur + k) % NW;
            end
        end
        if (found) mCur = nxt;
        else       mRunning = 1'b0;

        checkOutput("post_state", core_state, mRunning ? FETCH : IDLE);
        checkOutput("post_warp_done", warp_done, mDone);
        checkOutput("post_diverged", diverged, mDiv);
        checkOutput("post_done", done, !mRunning);
        checkOutput("post_cycle_count", cycle_count, PERF ? mCycles : 0);
        checkOutput("post_instr_count", instr_count, PERF ? mInstrs : 0);
    endtask

    task automatic finishKernel(input int cap);
        int n, w;
        n = 0;
        while (mRunning && n < cap) begin
            applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b1, {4{mPc[mCur]}}, 3'd0), w);
            n++;
        end
        checkOutput("kernel_finished", mRunning, 0);
        @(negedge clk);
        checkOutput("done_hold", done, 1);
    endtask

    vec_t tbl [7];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w, n;
        tbl[0] = '{mkIns(4'hF, 1'b0, 12'd0, 1'b0, {4{8'd1}}, 3'd0), 8'd1, 1'b0, 4'd0};
        tbl[1] = '{mkIns(4'b0101, 1'b1, {3'd7, 3'd0, 3'd7, 3'd0}, 1'b0, {4{8'd2}}, 3'd2), 8'd2, 1'b0, 4'd1};
        tbl[2] = '{mkIns(4'b0101, 1'b1, {3'd7, 3'd4, 3'd7, 3'd0}, 1'b0, {4{8'd3}}, 3'd0), 8'd3, 1'b0, 4'd5};
        tbl[3] = '{mkIns(4'b1011, 1'b0, 12'd0, 1'b0, {8'd5, 8'd9, 8'd5, 8'd5}, 3'd0), 8'd5, 1'b0, 4'd0};
        tbl[4] = '{mkIns(4'hF, 1'b0, 12'd0, 1'b0, {8'd5, 8'd9, 8'd5, 8'd5}, 3'd1), 8'd5, 1'b1, 4'd0};
        tbl[5] = '{mkIns(4'h0, 1'b1, {4{3'd3}}, 1'b0, {8'd32, 8'd33, 8'd34, 8'd7}, 3'd0), 8'd7, 1'b1, 4'd1};
        tbl[6] = '{mkIns(4'hF, 1'b0, 12'd0, 1'b1, {4{8'd7}}, 3'd0), 8'd7, 1'b1, 4'd0};

        rst = 1'b1; start = 1'b0; warp_count = 3'd0; thread_mask = 4'h0; fetch_done = 1'b0;
        mem_read_en = 1'b0; mem_write_en = 1'b0; is_ret = 1'b0; lsu_done = 4'h0;
        for (int t = 0; t < TPW; t++) next_pc[t] = 8'd0;
        mRunning = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", core_state, IDLE);
        checkOutput("reset_pc", current_pc, 0);
        checkOutput("reset_warp", current_warp, 0);
        checkOutput("reset_warp_done", warp_done, 0);
        checkOutput("reset_div_done", {diverged, done}, 0);
        checkOutput("reset_counters", cycle_count | instr_count, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single warp: three ALU instructions then RET");
        startKernel(1);
        for (int k = 1; k <= 3; k++) applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b0, {4{8'(k)}}, 3'd0), w);
        applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b1, {4{8'd3}}, 3'd0), w);
        checkOutput("basic_busy_cycles", int'(($time - tStart) / 10), 20);
        checkOutput("basic_final_pc", current_pc, 3);
        @(negedge clk);
        checkOutput("done_hold", done, 1);

        $display("[TB] vector table");
        startKernel(1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].ins, w);
            checkOutput("tbl_pc", current_pc, tbl[i].expPc);
            checkOutput("tbl_diverged", diverged, tbl[i].expDiv);
            checkOutput("tbl_wait", w, tbl[i].expWait);
        end
        @(negedge clk);
        checkOutput("done_hold", done, 1);
        startKernel(1);
        checkOutput("div_cleared_by_start", diverged, 0);
        finishKernel(4);

        $display("[TB] three warps round robin");
        startKernel(3);
        for (int k = 0; k < 6; k++) begin
            checkOutput("rr_order", current_warp, k % 3);
            applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b0, {4{8'(10 + k)}}, 3'd0), w);
        end
        finishKernel(8);

        $display("[TB] warp 1 retires first");
        startKernel(3);
        applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b0, {4{8'd4}}, 3'd0), w);
        applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b1, {4{8'd0}}, 3'd0), w);
        checkOutput("ret1_warp_done", warp_done, 4'b1010);
        checkOutput("ret1_next_warp", current_warp, 2);
        applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b0, {4{8'd6}}, 3'd0), w);
        checkOutput("ret1_wrap_warp", current_warp, 0);
        applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b0, {4{8'd8}}, 3'd0), w);
        applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b1, {4{8'd6}}, 3'd0), w);
        checkOutput("ret2_warp_done", warp_done, 4'b1110);
        checkOutput("ret2_not_done", done, 0);
        applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b1, {4{8'd8}}, 3'd0), w);
        checkOutput("ret3_done", done, 1);
        @(negedge clk);

        $display("[TB] warp_count clamping");
        startKernel(0);
        checkOutput("count0_warp_done", warp_done, 4'b1110);
        finishKernel(2);
        startKernel(7);
        checkOutput("count7_warp_done", warp_done, 4'b0000);
        finishKernel(6);

        $display("[TB] reset during WAIT");
        startKernel(2);
        applyStimulus(mkIns(4'hF, 1'b0, 12'd0, 1'b0, {8'd9, 8'd9, 8'd3, 8'd9}, 3'd0), w);
        thread_mask = 4'hF; fetch_done = 1'b1;
        @(negedge clk);
        fetch_done = 1'b0; mem_read_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_read_en = 1'b0;
        checkOutput("rst_in_wait", core_state, WAIT);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mRunning = 1'b0;
        checkOutput("rst_state", core_state, IDLE);
        checkOutput("rst_pc", current_pc, 0);
        checkOutput("rst_warp", current_warp, 0);
        checkOutput("rst_warp_done", warp_done, 0);
        checkOutput("rst_div_done", {diverged, done}, 0);
        checkOutput("rst_counters", cycle_count | instr_count, 0);
        @(negedge clk);
        checkOutput("rst_stays_idle", core_state, IDLE);

        $display("[TB] randomized kernels");
        for (int k = 0; k < 25; k++) begin
            startKernel($urandom_range(0, 7));
            n = 0;
            while (mRunning && n < 80) begin
                applyStimulus(randIns(), w);
                n++;
            end
            finishKernel(8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
